// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop synchronizer, start/data/parity/stop FSM, ready/valid output holding register.
// Optional parity checking is compiled in when the UART_RX_PARITY_EN macro is defined.
module uart_rx_ovs #(
    parameter int NB_DATA    = 8,
    parameter int OVS        = 16,
    parameter int NB_STOP    = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_err,
    output logic               o_parity_err,
    output logic               o_overrun,
    output logic               o_busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);

    if ((NB_DATA < 5) || (NB_DATA > 9) || (OVS < 8) || (OVS > 32) || ((OVS % 2) != 0) ||
        (NB_STOP < 1) || (NB_STOP > 2) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
        $error("uart_rx_ovs: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = 1'(PARITY_ODD);

    function automatic logic parity_mismatch(input logic [NB_DATA-1:0] d, input logic b);
        return b ^ (^d) ^ PAR_ODD;
    endfunction
`endif

    logic               meta_q, sync_q, prev_q;
    logic [2:0]         vld_q;
    logic               fall_s;
    logic               accept_s;

    state_t             state_q;
    logic [TW-1:0]      tick_q;
    logic [BW-1:0]      bit_q;
    logic [NB_DATA-1:0] shreg_q;
    logic               ferr_res_q, perr_res_q, done_q, busy_q;

    logic [NB_DATA-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               perr_q, perr_d;
    logic               ovr_q, ovr_d;

    // Line synchronizer; vld_q marks when prev_q holds a genuine line sample so
    // the reset value of the flops can never masquerade as a falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            vld_q  <= 3'b000;
        end else begin
            meta_q <= i_rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
            vld_q  <= {vld_q[1:0], 1'b1};
        end
    end

    assign fall_s = vld_q[2] & prev_q & ~sync_q;

    // Receive FSM: tick counting, bit sampling, error accumulation and frame-done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            ferr_res_q <= 1'b0;
            perr_res_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tick_q <= '0;
                    bit_q  <= '0;
                    if (fall_s) begin
                        state_q    <= START;
                        busy_q     <= 1'b1;
                        ferr_res_q <= 1'b0;
                        perr_res_q <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (tick_q == HALF_LAST) begin
                            tick_q <= '0;
                            if (sync_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DATA;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_q == FULL_LAST) begin
                            tick_q  <= '0;
                            shreg_q <= {sync_q, shreg_q[NB_DATA-1:1]};
                            if (bit_q == DATA_LAST) begin
                                bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_tick) begin
                        if (tick_q == FULL_LAST) begin
                            tick_q     <= '0;
                            perr_res_q <= parity_mismatch(shreg_q, sync_q);
                            state_q    <= STOP;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_tick) begin
                        if (tick_q == FULL_LAST) begin
                            tick_q <= '0;
                            if (!sync_q) begin
                                ferr_res_q <= 1'b1;
                            end
                            if (bit_q == STOP_LAST) begin
                                bit_q   <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register next state: load wins over accept, overrun only when nobody took the old frame.
    always_comb begin
        accept_s = valid_q & i_ready;
        data_d   = data_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (done_q) begin
            data_d  = shreg_q;
            ferr_d  = ferr_res_q;
            perr_d  = perr_res_q;
            valid_d = 1'b1;
            if (valid_q && !i_ready) begin
                ovr_d = 1'b1;
            end else if (accept_s) begin
                ovr_d = 1'b0;
            end else begin
                ovr_d = ovr_q;
            end
        end else if (accept_s) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
            ovr_d   = ovr_q;
        end
    end

    // Output holding register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_parity_err = perr_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = busy_q;

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVS, default 16, i_tick strobes per bit period; even, legal range 8..32.
REQ-003 Parameter NB_STOP, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; used only under REQ-026.
REQ-005 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_tick  input  1  single-cycle oversampling strobe at baud*OVS.
REQ-008 i_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-009 i_ready  input  1  consumer accepts o_data when high while o_valid is high.
REQ-010 o_data  output  NB_DATA  received word, LSB first on the line.
REQ-011 o_valid  output  1  o_data and the flags hold a frame not yet accepted.
REQ-012 o_frame_err  output  1  stop-bit error for the held frame; qualified by o_valid.
REQ-013 o_parity_err  output  1  parity error for the held frame; qualified by o_valid.
REQ-014 o_overrun  output  1  an unaccepted frame was overwritten; sticky.
REQ-015 o_busy  output  1  high in every state except IDLE.

Function
REQ-016 i_rx shall pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value.
REQ-017 The FSM shall have states IDLE, START, DATA, PARITY, STOP; the tick counter advances only on cycles with i_tick=1.
REQ-018 IDLE->START on a synchronized 1->0 transition; a line held low does not retrigger.
REQ-019 START shall count OVS/2 ticks; at that point, rx=1 shall return to IDLE (false start, no output); rx=0 shall clear the tick counter and enter DATA.
REQ-020 DATA shall sample rx every OVS ticks and shift it in at the MSB (LSB-first line order); after NB_DATA samples it shall enter PARITY if compiled, else STOP.
REQ-021 STOP shall sample NB_STOP bits at OVS-tick spacing; any sampled 0 sets the frame-error result; after the last stop sample the FSM returns to IDLE.
REQ-022 On the clock edge after the last stop sample: o_data <= shift register, o_frame_err and o_parity_err <= results, o_valid <= 1; the frame is delivered even when errored.
REQ-023 o_valid shall clear on the first rising edge with o_valid=1 and i_ready=1, unless a new frame loads on the same edge.
REQ-024 New frame loading while o_valid=1 and i_ready=0: the new frame overwrites the held frame, o_valid stays 1, and o_overrun <= 1; o_overrun clears on the next accepted transfer.
REQ-025 New frame loading on the same edge as an acceptance: no overrun is flagged, and o_valid stays 1 with the new frame.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: a PARITY state samples one bit OVS ticks after the last data bit and checks it against XOR(data)^PARITY_ODD; a mismatch sets o_parity_err. Macro undefined: no PARITY state, o_parity_err is constant 0, and the frame length is 1+NB_DATA+NB_STOP bits.

Reset
REQ-027 i_rst shall force: FSM to IDLE; all counters and the shift register to 0; synchronizer flops to 1; o_data, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy to 0; this applies in any state, including mid-frame.
REQ-028 After i_rst deasserts mid-frame, the remaining frame bits shall not produce o_valid unless they contain a valid 1->0 start edge.

Verification
REQ-029 OVS=16, NB_DATA=8, no parity; send 0xA5 with stop=1 -> o_data=0xA5, o_valid=1, all error flags 0; i_ready=1 clears o_valid next edge.
REQ-030 Drive rx low for 4 ticks, then high -> o_valid stays 0, FSM returns to IDLE, o_busy=0 within OVS/2 ticks.
REQ-031 Send 0x3C with stop bit=0 -> o_data=0x3C, o_valid=1, o_frame_err=1.
REQ-032 i_ready=0; send 0x11 then 0x22 -> o_data=0x22, o_overrun=1; raise i_ready -> o_valid=0 and o_overrun=0 after one edge.
REQ-033 UART_RX_PARITY_EN defined, PARITY_ODD=0; send 0x07 with parity bit 0 -> o_parity_err=1; repeat with parity bit 1 -> o_parity_err=0.
REQ-034 Assert i_rst during DATA bit 4 of a frame -> all outputs 0 immediately; the next clean frame 0x5A is received correctly.
